wave_control: RTL and testbench
===============================

Name: wave_control

Overview:
- MCU-to-FPGA control register file on the same parallel MCU bus used by the waveform readback path.
- MCU latches a register address, then writes data words. The block decodes them into waveform configuration: divider, gain, frequency word, run/clear controls.
- Divider and gain are double-buffered and applied glitch-free at a waveform period boundary.
- The 32-bit frequency word is committed atomically from two 16-bit halves.

Parameters:
- DATA_WIDTH, 16, MCU bus data width.
- FREQ_WIDTH, 32, frequency word width; must satisfy DATA_WIDTH < FREQ_WIDTH <= 2*DATA_WIDTH.
- DIV_WIDTH, 12, divider output width; must be <= DATA_WIDTH.
- DIV_RESET, 1, divider value after reset.

Ports:
- clk  in  1  system clock (200 MHz).
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; when low, all bus strobes are ignored.
- addr_en  in  1  one-cycle strobe; latch rd_data as register address.
- rd_en  in  1  one-cycle strobe; MCU write, rd_data holds the data word.
- rd_data  in  DATA_WIDTH  MCU bus data (address or data).
- wave_sync  in  1  one-cycle pulse at each waveform period start.
- div  out  DIV_WIDTH  active divider.
- gain_ctrl  out  2  active gain control.
- freq_word  out  FREQ_WIDTH  active frequency tuning word.
- freq_update  out  1  one-cycle pulse after freq_word changes.
- run  out  1  waveform run enable.
- soft_clr  out  1  one-cycle clear pulse.
- cfg_pending  out  1  shadow div/gain not yet applied.
- bad_addr  out  1  sticky flag: write to an unmapped address.

Behaviour:

Address map:
- 0: DIV. Shadow div gets rd_data[DIV_WIDTH-1:0].
- 1: GAIN. Shadow gain gets rd_data[1:0].
- 2: FREQ_LOW. Low shadow gets rd_data.
- 3: FREQ_HIGH. Commit: freq_word gets {rd_data[FREQ_WIDTH-DATA_WIDTH-1:0], low shadow}.
- 4: CTRL.
  - bit0: run (level).
  - bit1: soft_clr (pulse).
  - bit2: force_apply (pulse, not stored).
- Other addresses: no register changes; bad_addr set to 1.

Reset values (rst sampled high at an edge):
- div = DIV_RESET; both shadows (div, gain) match the active values.
- gain_ctrl = 0; freq_word = 0; low shadow = 0.
- run = 0; freq_update = 0; soft_clr = 0; cfg_pending = 0; bad_addr = 0.
- Latched address = 0.
- Reset mid-sequence discards any pending shadow values and any half-written frequency word.

Bus decode:
- addr_en high at edge k: address latched at edge k.
- rd_en high at edge k: write decoded against the address latched before edge k.
- addr_en and rd_en both high in the same cycle: addr_en wins; the write is dropped.
- en low: addr_en and rd_en are ignored. Internal state still progresses (apply on wave_sync, pulses deassert).
- Address is not auto-incremented. Repeated rd_en strobes write the same register.

Shadow/apply (div, gain):
- A write to addr 0 or 1 at edge k updates the shadow and sets cfg_pending at edge k.
- Apply copies both shadows to div/gain and clears cfg_pending. Apply fires at edge k+1 when any of the following holds:
  - cfg_pending=1 and run=0 (one-cycle latency);
  - cfg_pending=1 and wave_sync=1 in that cycle;
  - force_apply was written at edge k (applies regardless of cfg_pending).
- If a shadow write and an apply land on the same edge:
  - the apply uses the pre-write shadow values;
  - cfg_pending stays 1 so the new value applies later.
- If run is 1 and no wave_sync arrives, shadows stay pending indefinitely.

Frequency commit:
- FREQ_LOW alone never changes freq_word.
- FREQ_HIGH write at edge k: freq_word updated at edge k, freq_update=1 for the single cycle after edge k. This applies regardless of run.
- Back-to-back FREQ_HIGH writes produce back-to-back pulses.
- High bits of rd_data beyond FREQ_WIDTH-DATA_WIDTH are discarded.

CTRL:
- run updates at the write edge.
- soft_clr is high for exactly one cycle after a CTRL write with bit1=1.
- Writing run=0 while cfg_pending=1 applies at the next edge.

bad_addr:
- Cleared only by rst.

Test Plan:
1. Reset, then idle -> div=1, gain_ctrl=0, freq_word=0, run=0, all flags 0.
2. run=0. addr_en with 0, rd_en with 0x0123 -> cfg_pending 1 for one cycle; div=0x123 one cycle after the write edge. Data 0xF456 -> div=0x456.
3. run=1 (CTRL=0x0001). Write GAIN=2 -> gain_ctrl stays 0 and cfg_pending=1 until wave_sync is pulsed; gain_ctrl=2 the edge after wave_sync. Repeat with CTRL=0x0005 instead of wave_sync -> immediate apply.
4. FREQ_LOW=0xBEEF, then FREQ_HIGH=0xDEAD -> freq_word stays 0 after the low write, becomes 0xDEADBEEF on the high write, single freq_update pulse. A second FREQ_LOW write leaves freq_word unchanged.
5. Corner cases:
   - addr_en and rd_en asserted together -> write dropped.
   - Write to address 7 -> bad_addr=1 and stays 1; no register changes.
   - en=0 with strobes -> no changes.
6. Shadow DIV=5 pending with run=1, then rst mid-sequence -> div=DIV_RESET, cfg_pending=0; a later wave_sync does not apply 5.

Source files
------------

// File: rtl/wave_control.sv
// -----------------------------------------------------------------------------
// wave_control
//
// MCU-to-FPGA control register file. It sits on the same parallel MCU bus as
// the waveform readback path. The MCU first latches a register address with
// addr_en, then writes data words with rd_en. The block turns those writes
// into the waveform configuration.
//
// Divider and gain are double-buffered. The MCU writes a shadow copy, and the
// shadow is moved into the active outputs at a safe moment:
//   - at a waveform period start (wave_sync) while running,
//   - on the next edge when the waveform is stopped, or
//   - when force_apply is written.
//
// The frequency word is committed atomically. FREQ_LOW only loads a holding
// register. FREQ_HIGH writes the whole word in one edge.
//
// Address map (relative to the latched address):
//   0 DIV       shadow div  <= rd_data[DIV_WIDTH-1:0]
//   1 GAIN      shadow gain <= rd_data[1:0]
//   2 FREQ_LOW  low half holding register
//   3 FREQ_HIGH freq_word <= {rd_data[FREQ_WIDTH-DATA_WIDTH-1:0], low half}
//   4 CTRL      bit0 run (level), bit1 soft_clr (pulse), bit2 force_apply
//   other       no register change, sticky bad_addr
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           block enable; bus strobes are ignored while low
//   addr_en      strobe: latch rd_data as the register address
//   rd_en        strobe: write rd_data to the latched address
//   rd_data      MCU bus data (address or data word)
//   wave_sync    one-cycle pulse at each waveform period start
//   div          active divider
//   gain_ctrl    active gain control
//   freq_word    active frequency tuning word
//   freq_update  one-cycle pulse after freq_word is written
//   run          waveform run enable
//   soft_clr     one-cycle clear pulse
//   cfg_pending  shadow div/gain written but not yet applied
//   bad_addr     sticky flag: a write hit an unmapped address
//
// Parameter constraints:
//   DATA_WIDTH < FREQ_WIDTH <= 2*DATA_WIDTH
//   DIV_WIDTH <= DATA_WIDTH
// -----------------------------------------------------------------------------
module wave_control #(
    parameter int DATA_WIDTH = 16,
    parameter int FREQ_WIDTH = 32,
    parameter int DIV_WIDTH  = 12,
    parameter int DIV_RESET  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  addr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wave_sync,
    output logic [DIV_WIDTH-1:0]  div,
    output logic [1:0]            gain_ctrl,
    output logic [FREQ_WIDTH-1:0] freq_word,
    output logic                  freq_update,
    output logic                  run,
    output logic                  soft_clr,
    output logic                  cfg_pending,
    output logic                  bad_addr
);

    localparam int HI_WIDTH = FREQ_WIDTH - DATA_WIDTH;

    localparam logic [DIV_WIDTH-1:0] DIV_INIT = DIV_WIDTH'(DIV_RESET);

    localparam logic [DATA_WIDTH-1:0] ADDR_DIV       = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] ADDR_GAIN      = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ADDR_FREQ_LOW  = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] ADDR_FREQ_HIGH = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] ADDR_CTRL      = DATA_WIDTH'(4);

    // Bus and shadow state.
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DIV_WIDTH-1:0]  shadow_div;
    logic [1:0]            shadow_gain;
    logic [DATA_WIDTH-1:0] freq_low;
    logic                  force_q;     // force_apply seen at the previous edge

    // Strobe qualification: addr_en has priority over a simultaneous rd_en.
    logic addr_wr;
    logic bus_wr;

    assign addr_wr = en & addr_en;
    assign bus_wr  = en & rd_en & ~addr_en;

    // Per-register write decode.
    logic wr_div;
    logic wr_gain;
    logic wr_low;
    logic wr_high;
    logic wr_ctrl;
    logic wr_bad;

    // NOTE: every signal driven here gets a default first, so that no path
    // through the case leaves a value held and no latch is inferred.
    always_comb begin
        wr_div  = 1'b0;
        wr_gain = 1'b0;
        wr_low  = 1'b0;
        wr_high = 1'b0;
        wr_ctrl = 1'b0;
        wr_bad  = 1'b0;
        if (bus_wr) begin
            case (addr_q)
                ADDR_DIV:       wr_div  = 1'b1;
                ADDR_GAIN:      wr_gain = 1'b1;
                ADDR_FREQ_LOW:  wr_low  = 1'b1;
                ADDR_FREQ_HIGH: wr_high = 1'b1;
                ADDR_CTRL:      wr_ctrl = 1'b1;
                default:        wr_bad  = 1'b1;
            endcase
        end
    end

    // Apply the shadows at this edge in any of these cases:
    //   - force_apply was written at the previous edge;
    //   - something is pending and the waveform is stopped;
    //   - something is pending and a new period starts now.
    // The apply path does not depend on en, so a pending value still lands
    // while the bus is disabled.
    logic apply;

    assign apply = force_q | (cfg_pending & (~run | wave_sync));

    // NOTE: all state is updated with non-blocking assignments. That way each
    // right-hand side reads the pre-edge value. An apply and a shadow write on
    // the same edge therefore see the old shadow, and the new shadow value
    // stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            shadow_div  <= DIV_INIT;
            shadow_gain <= 2'd0;
            freq_low    <= '0;
            force_q     <= 1'b0;
            div         <= DIV_INIT;
            gain_ctrl   <= 2'd0;
            freq_word   <= '0;
            freq_update <= 1'b0;
            run         <= 1'b0;
            soft_clr    <= 1'b0;
            cfg_pending <= 1'b0;
            bad_addr    <= 1'b0;
        end else begin
            // Pulses are high only for the cycle after their write.
            freq_update <= wr_high;
            soft_clr    <= wr_ctrl & rd_data[1];
            force_q     <= wr_ctrl & rd_data[2];

            if (addr_wr) begin
                addr_q <= rd_data;
            end

            if (apply) begin
                div       <= shadow_div;
                gain_ctrl <= shadow_gain;
            end

            if (wr_div) begin
                shadow_div <= rd_data[DIV_WIDTH-1:0];
            end
            if (wr_gain) begin
                shadow_gain <= rd_data[1:0];
            end

            // A fresh shadow write wins over a simultaneous apply, so the
            // newly written value is not lost.
            if (wr_div | wr_gain) begin
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end

            if (wr_low) begin
                freq_low <= rd_data;
            end
            if (wr_high) begin
                freq_word <= {rd_data[HI_WIDTH-1:0], freq_low};
            end

            if (wr_ctrl) begin
                run <= rd_data[0];
            end

            if (wr_bad) begin
                bad_addr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wave_control.sv
// -----------------------------------------------------------------------------
// tb_wave_control
//
// Directed bench for wave_control.
//
// A behavioural model follows the register-map rules one clock at a time:
//   - apply the pending shadows first;
//   - then perform the bus access.
// A compare process checks every DUT output against the model on each falling
// edge. Hand-computed literal checks along the sequence pin the model itself.
//
// Inputs change on the falling edge, so both the DUT and the model sample
// stable values at the rising edge.
// -----------------------------------------------------------------------------
module tb_wave_control;

    localparam int DATA_WIDTH = 16;
    localparam int FREQ_WIDTH = 32;
    localparam int DIV_WIDTH  = 12;
    localparam int DIV_RESET  = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  en = 1'b0;
    logic                  addr_en = 1'b0;
    logic                  rd_en = 1'b0;
    logic [DATA_WIDTH-1:0] rd_data = '0;
    logic                  wave_sync = 1'b0;
    logic [DIV_WIDTH-1:0]  div;
    logic [1:0]            gain_ctrl;
    logic [FREQ_WIDTH-1:0] freq_word;
    logic                  freq_update;
    logic                  run;
    logic                  soft_clr;
    logic                  cfg_pending;
    logic                  bad_addr;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit checking     = 1'b0;

    wave_control #(
        .DATA_WIDTH (DATA_WIDTH),
        .FREQ_WIDTH (FREQ_WIDTH),
        .DIV_WIDTH  (DIV_WIDTH),
        .DIV_RESET  (DIV_RESET)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .addr_en     (addr_en),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .wave_sync   (wave_sync),
        .div         (div),
        .gain_ctrl   (gain_ctrl),
        .freq_word   (freq_word),
        .freq_update (freq_update),
        .run         (run),
        .soft_clr    (soft_clr),
        .cfg_pending (cfg_pending),
        .bad_addr    (bad_addr)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    longint m_addr;
    longint m_sdiv;
    longint m_sgain;
    longint m_low;
    longint m_div;
    longint m_gain;
    longint m_freq;
    bit     m_upd;
    bit     m_run;
    bit     m_clr;
    bit     m_pend;
    bit     m_bad;
    bit     m_force;

    always @(posedge clk) begin
        if (rst) begin
            m_addr  = 0;
            m_sdiv  = DIV_RESET;
            m_sgain = 0;
            m_low   = 0;
            m_div   = DIV_RESET;
            m_gain  = 0;
            m_freq  = 0;
            m_upd   = 0;
            m_run   = 0;
            m_clr   = 0;
            m_pend  = 0;
            m_bad   = 0;
            m_force = 0;
        end else begin
            // Step 1: settle any pending apply using the shadows from before
            // this edge.
            if (m_force || (m_pend && (!m_run || wave_sync))) begin
                m_div  = m_sdiv;
                m_gain = m_sgain;
                m_pend = 0;
            end
            m_force = 0;
            m_upd   = 0;
            m_clr   = 0;

            // Step 2: perform the bus access.
            if (en && addr_en) begin
                m_addr = rd_data;
            end else if (en && rd_en) begin
                case (m_addr)
                    0: begin
                        m_sdiv = rd_data % (1 << DIV_WIDTH);
                        m_pend = 1;
                    end
                    1: begin
                        m_sgain = rd_data % 4;
                        m_pend  = 1;
                    end
                    2: m_low = rd_data;
                    3: begin
                        m_freq = ((rd_data % (64'd1 << (FREQ_WIDTH - DATA_WIDTH)))
                                  << DATA_WIDTH) + m_low;
                        m_upd  = 1;
                    end
                    4: begin
                        m_run   = rd_data[0];
                        m_clr   = rd_data[1];
                        m_force = rd_data[2];
                    end
                    default: m_bad = 1;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- checks
    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // Compare process: every cycle after reset, all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("cycle_outputs",
                  {13'd0, div, gain_ctrl, freq_word, freq_update, run,
                   soft_clr, cfg_pending, bad_addr},
                  {13'd0, m_div[DIV_WIDTH-1:0], m_gain[1:0],
                   m_freq[FREQ_WIDTH-1:0], m_upd, m_run, m_clr, m_pend,
                   m_bad});
        end
    end

    // ------------------------------------------------------------- stimulus
    // Each call drives one clock cycle, entering and leaving on a falling edge.
    task automatic tick(input bit e, input bit ae, input bit re,
                        input logic [DATA_WIDTH-1:0] d, input bit sync);
        en        = e;
        addr_en   = ae;
        rd_en     = re;
        rd_data   = d;
        wave_sync = sync;
        @(negedge clk);
        en        = 1'b0;
        addr_en   = 1'b0;
        rd_en     = 1'b0;
        wave_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic set_addr(input logic [DATA_WIDTH-1:0] a);
        tick(1'b1, 1'b1, 1'b0, a, 1'b0);
    endtask

    task automatic write(input logic [DATA_WIDTH-1:0] d);
        tick(1'b1, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic wr_reg(input logic [DATA_WIDTH-1:0] a,
                          input logic [DATA_WIDTH-1:0] d);
        set_addr(a);
        write(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        checking = 1'b1;

        // 1. Reset, then idle.
        idle(2);
        check("reset_div", 64'(div), 64'h1);
        check("reset_gain", 64'(gain_ctrl), 64'h0);
        check("reset_freq", 64'(freq_word), 64'h0);
        check("reset_flags",
              64'({freq_update, run, soft_clr, cfg_pending, bad_addr}), 64'h0);

        // 2. Divider with run=0: one-cycle apply latency, upper bits dropped.
        set_addr(16'h0000);
        write(16'h0123);
        check("div_pending", 64'(cfg_pending), 64'h1);
        check("div_not_yet", 64'(div), 64'h1);
        idle(1);
        check("div_applied", 64'(div), 64'h123);
        check("div_pend_clr", 64'(cfg_pending), 64'h0);
        write(16'hF456);
        idle(1);
        check("div_trunc", 64'(div), 64'h456);

        // 3. Gain with run=1: held until wave_sync, then force_apply.
        wr_reg(16'd4, 16'h0001);
        check("run_set", 64'(run), 64'h1);
        wr_reg(16'd1, 16'h0002);
        idle(3);
        check("gain_held", 64'(gain_ctrl), 64'h0);
        check("gain_pend", 64'(cfg_pending), 64'h1);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("gain_sync", 64'(gain_ctrl), 64'h2);
        wr_reg(16'd1, 16'h0003);
        idle(2);
        check("gain_held2", 64'(gain_ctrl), 64'h2);
        wr_reg(16'd4, 16'h0005);
        idle(1);
        check("gain_force", 64'(gain_ctrl), 64'h3);
        check("force_run", 64'(run), 64'h1);
        // Apply still runs while the bus is disabled.
        wr_reg(16'd1, 16'h0001);
        tick(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("gain_en0_sync", 64'(gain_ctrl), 64'h1);

        // 4. Frequency word commit.
        wr_reg(16'd2, 16'hBEEF);
        check("freq_low_only", 64'(freq_word), 64'h0);
        wr_reg(16'd3, 16'hDEAD);
        check("freq_commit", 64'(freq_word), 64'hDEADBEEF);
        check("freq_pulse", 64'(freq_update), 64'h1);
        idle(1);
        check("freq_pulse_end", 64'(freq_update), 64'h0);
        wr_reg(16'd2, 16'h1234);
        idle(1);
        check("freq_low_hold", 64'(freq_word), 64'hDEADBEEF);
        set_addr(16'd3);
        write(16'h0001);
        write(16'h0002);
        check("freq_b2b", 64'(freq_word), 64'h00021234);
        check("freq_b2b_pulse", 64'(freq_update), 64'h1);
        idle(1);

        // 5a. Simultaneous addr_en and rd_en: the write is dropped.
        set_addr(16'd0);
        tick(1'b1, 1'b1, 1'b1, 16'h0000, 1'b0);
        check("simul_drop", 64'(cfg_pending), 64'h0);

        // 5b. Unmapped address.
        set_addr(16'd7);
        write(16'h0003);
        idle(3);
        check("bad_sticky", 64'(bad_addr), 64'h1);
        check("bad_no_change", 64'({div, gain_ctrl}), 64'({12'h456, 2'd1}));

        // 5c. soft_clr pulse.
        wr_reg(16'd4, 16'h0003);
        check("soft_clr_hi", 64'(soft_clr), 64'h1);
        idle(1);
        check("soft_clr_lo", 64'(soft_clr), 64'h0);

        // 5d. Writing run=0 releases a pending shadow on the next edge.
        wr_reg(16'd0, 16'h0009);
        wr_reg(16'd4, 16'h0000);
        check("run0_pend", 64'({run, cfg_pending}), 64'h1);
        idle(1);
        check("run0_apply", 64'(div), 64'h9);

        // 5e. Shadow write and apply on the same edge.
        set_addr(16'd0);
        write(16'h000A);
        write(16'h000B);
        check("same_edge_old", 64'(div), 64'hA);
        check("same_edge_pend", 64'(cfg_pending), 64'h1);
        idle(1);
        check("same_edge_new", 64'(div), 64'hB);

        // 5f. en=0: neither strobe has any effect.
        tick(1'b0, 1'b0, 1'b1, 16'h0099, 1'b0);
        check("en0_write", 64'(cfg_pending), 64'h0);
        tick(1'b0, 1'b1, 1'b0, 16'h0003, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 16'h0AAA, 1'b0);
        check("en0_addr_kept", 64'(freq_word), 64'h00021234);
        idle(1);
        check("en0_div", 64'(div), 64'hAAA);

        // 6. Reset mid-sequence.
        wr_reg(16'd4, 16'h0001);
        wr_reg(16'd2, 16'h5555);
        wr_reg(16'd0, 16'h0005);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_div", 64'(div), 64'h1);
        check("rst_flags",
              64'({freq_update, run, soft_clr, cfg_pending, bad_addr}), 64'h0);
        check("rst_freq", 64'(freq_word), 64'h0);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("rst_sync_div", 64'(div), 64'h1);
        wr_reg(16'd3, 16'h0001);
        check("rst_low_clr", 64'(freq_word), 64'h00010000);
        idle(2);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
